// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory req/ack port,
// parks one returned word while stalled, and loads IF/ID. Optional counters under IF_STAT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        if_flush,
  input  logic [31:0] branch_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [5:0]  op
`ifdef IF_STAT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        do_load;
  logic [31:0] load_word;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    redir_d   = redir_q;
    hold_d    = hold_q;
    do_load   = 1'b0;
    load_word = 32'h0;

    case (state_q)
      FETCH: begin
        if (!req_q) begin
          // First cycle out of reset: no transaction outstanding yet.
          req_d = 1'b1;
          if (if_flush) pc_d = branch_target;
        end else if (imem_ack) begin
          if (pend_q || if_flush) begin
            pc_d   = if_flush ? branch_target : redir_q;
            pend_d = 1'b0;
          end else if (stall) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
            req_d   = 1'b0;
          end else begin
            do_load   = 1'b1;
            load_word = imem_rdata;
            pc_d      = pc_plus4;
          end
        end else if (if_flush) begin
          // Address must not move mid-transaction; remember where to go on ack.
          pend_d  = 1'b1;
          redir_d = branch_target;
        end
      end
      HOLD: begin
        if (if_flush) begin
          pc_d    = branch_target;
          state_d = FETCH;
          req_d   = 1'b1;
        end else if (!stall) begin
          do_load   = 1'b1;
          load_word = hold_q;
          pc_d      = pc_plus4;
          state_d   = FETCH;
          req_d     = 1'b1;
        end
      end
      default: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
    endcase
  end

  // IF/ID register: flush > stall > load > bubble; pc4 only moves on a load.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (if_flush) begin
      instr_d = 32'h0;
      valid_d = 1'b0;
    end else if (stall) begin
      instr_d = instr_q;
    end else if (do_load) begin
      instr_d = load_word;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end else begin
      instr_d = 32'h0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      pend_q  <= 1'b0;
      redir_q <= 32'h0;
      hold_q  <= 32'h0;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      redir_q <= redir_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;
  assign op         = instr_q[31:26];

`ifdef IF_STAT_EN
  logic [31:0] fetch_cnt_q;
  logic [15:0] flush_cnt_q;

  // A load only lands when neither flush nor stall overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0;
      flush_cnt_q <= 16'h0;
    end else begin
      if (do_load && !if_flush && !stall) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (if_flush) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed test-plan scenarios with literal
// expectations, then randomized traffic checked every cycle against a behavioural model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        if_flush;
  logic [31:0] branch_target;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [5:0]  op;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic        w_valid;
  logic [5:0]  w_op;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_stall;
  logic        w_flush;
  logic [31:0] w_tgt;

`ifdef IF_STAT_EN
  logic [31:0] fetch_count, w_fetch_count;
  logic [15:0] flush_count, w_flush_count;
`endif

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .if_flush(if_flush),
    .branch_target(branch_target), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .op(op)
`ifdef IF_STAT_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  // Zero-wait memory around a second instance that starts at the top of the address space.
  assign w_ack   = w_req;
  assign w_rdata = 32'h1234_5678;
  assign w_stall = 1'b0;
  assign w_flush = 1'b0;
  assign w_tgt   = 32'h0;

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) wdut (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .stall(w_stall), .if_flush(w_flush),
    .branch_target(w_tgt), .ifid_instr(w_instr), .ifid_pc4(w_pc4),
    .ifid_valid(w_valid), .op(w_op)
`ifdef IF_STAT_EN
    , .fetch_count(w_fetch_count), .flush_count(w_flush_count)
`endif
  );

  int nvec = 0;
  int nerr = 0;
  bit run  = 0;

  // Behavioural model state.
  bit          m_req, m_parked, m_pend, m_valid;
  logic [31:0] m_pc, m_tgt, m_buf, m_instr, m_pc4;
  logic [31:0] m_fc;
  logic [15:0] m_flc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_parked = 0; m_pend = 0; m_valid = 0;
    m_pc = 32'h0; m_tgt = 32'h0; m_buf = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
    m_fc = 32'h0; m_flc = 16'h0;
  endtask

  // One clock of the fetch rules: decide what word (if any) is delivered, where the PC goes.
  task automatic model_step();
    bit          deliver;
    logic [31:0] word;
    deliver = 0;
    word    = 32'h0;
    if (m_parked) begin
      if (if_flush) begin
        m_pc = branch_target; m_parked = 0; m_req = 1;
      end else if (!stall) begin
        deliver = 1; word = m_buf; m_parked = 0; m_req = 1;
      end
    end else if (!m_req) begin
      m_req = 1;
      if (if_flush) m_pc = branch_target;
    end else if (imem_ack) begin
      if (if_flush) begin
        m_pc = branch_target; m_pend = 0;
      end else if (m_pend) begin
        m_pc = m_tgt; m_pend = 0;
      end else if (stall) begin
        m_buf = imem_rdata; m_parked = 1; m_req = 0;
      end else begin
        deliver = 1; word = imem_rdata;
      end
    end else if (if_flush) begin
      m_pend = 1; m_tgt = branch_target;
    end

    if (if_flush) begin
      m_valid = 0; m_instr = 32'h0;
    end else if (!stall) begin
      if (deliver) begin
        m_instr = word;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1;
        m_pc    = m_pc + 32'd4;
        m_fc    = m_fc + 32'd1;
      end else begin
        m_valid = 0; m_instr = 32'h0;
      end
    end
    if (if_flush) m_flc = m_flc + 16'd1;
  endtask

  task automatic cyc(input logic a, input logic [31:0] d, input logic s,
                     input logic f, input logic [31:0] t);
    imem_ack = a; imem_rdata = d; stall = s; if_flush = f; branch_target = t;
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (run) begin
      check("imem_req",   {31'h0, imem_req},   {31'h0, m_req});
      check("imem_addr",  imem_addr,           m_pc);
      check("ifid_instr", ifid_instr,          m_instr);
      check("ifid_pc4",   ifid_pc4,            m_pc4);
      check("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
      check("op",         {26'h0, op},         {26'h0, m_instr[31:26]});
`ifdef IF_STAT_EN
      check("fetch_count", fetch_count, m_fc);
      check("flush_count", {16'h0, flush_count}, {16'h0, m_flc});
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, elapsed %0t required below 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    imem_ack = 0; imem_rdata = 0; stall = 0; if_flush = 0; branch_target = 0;
    model_reset();
    run = 1;
    repeat (2) cyc(0, 0, 0, 0, 0);
    check("rst_req",   {31'h0, imem_req},   32'h0);
    check("rst_valid", {31'h0, ifid_valid}, 32'h0);
    check("rst_instr", ifid_instr, 32'h0);
    check("rst_pc4",   ifid_pc4,   32'h0);
    rst_n = 1'b1;

    // Back-to-back fetch with zero-wait memory.
    cyc(0, 0, 0, 0, 0);
    check("rel_req",  {31'h0, imem_req}, 32'h1);
    check("rel_addr", imem_addr, 32'h0);
    check("w_addr0",  w_addr, 32'hFFFF_FFFC);
    cyc(1, 32'h8C01_0004, 0, 0, 0);
    check("i0_instr", ifid_instr, 32'h8C01_0004);
    check("i0_pc4",   ifid_pc4, 32'h4);
    check("i0_op",    {26'h0, op}, 32'h23);
    check("i0_model_pc4", m_pc4, 32'h4);
    check("w_pc4_wrap", w_pc4, 32'h0);
    check("w_addr1",  w_addr, 32'h0);
    cyc(1, 32'h0022_1820, 0, 0, 0);
    check("i1_pc4",   ifid_pc4, 32'h8);
    check("i1_op",    {26'h0, op}, 32'h00);
    check("i1_valid", {31'h0, ifid_valid}, 32'h1);
`ifdef IF_STAT_EN
    check("w_fetch_count", w_fetch_count, 32'h2);
`endif
    cyc(1, 32'h1000_0002, 0, 0, 0);
    check("i2_pc4",   ifid_pc4, 32'hC);
    check("i2_op",    {26'h0, op}, 32'h04);

    // Two wait states at PC=0x10.
    cyc(1, 32'h0, 0, 0, 0);
    check("ws_addr1", imem_addr, 32'h10);
    cyc(0, 0, 0, 0, 0);
    check("ws_addr2", imem_addr, 32'h10);
    check("ws_valid", {31'h0, ifid_valid}, 32'h0);
    cyc(0, 0, 0, 0, 0);
    check("ws_addr3", imem_addr, 32'h10);
    cyc(1, 32'h2001_0005, 0, 0, 0);
    check("ws_valid_after", {31'h0, ifid_valid}, 32'h1);
    check("ws_pc4", ifid_pc4, 32'h14);

    // Stall while the word at 0x20 returns.
    cyc(1, 32'h0000_0014, 0, 0, 0);
    cyc(1, 32'h0000_0018, 0, 0, 0);
    cyc(1, 32'h0000_001C, 0, 0, 0);
    check("st_addr", imem_addr, 32'h20);
    cyc(1, 32'hAC02_0008, 1, 0, 0);
    check("st_req0", {31'h0, imem_req}, 32'h0);
    check("st_hold", ifid_instr, 32'h0000_001C);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("st_req2", {31'h0, imem_req}, 32'h0);
    check("st_pc4_held", ifid_pc4, 32'h20);
    cyc(0, 0, 0, 0, 0);
    check("st_instr", ifid_instr, 32'hAC02_0008);
    check("st_pc4", ifid_pc4, 32'h24);
    check("st_next_addr", imem_addr, 32'h24);

    // Flush while a fetch at 0x30 waits for its ack.
    cyc(1, 32'h24, 0, 0, 0);
    cyc(1, 32'h28, 0, 0, 0);
    cyc(1, 32'h2C, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h40);
    check("fl_addr_hold", imem_addr, 32'h30);
    check("fl_valid", {31'h0, ifid_valid}, 32'h0);
    cyc(0, 0, 0, 0, 0);
    check("fl_addr_hold2", imem_addr, 32'h30);
    cyc(1, 32'hDEAD_BEEF, 0, 0, 0);
    check("fl_discard", {31'h0, ifid_valid}, 32'h0);
    check("fl_next", imem_addr, 32'h40);
    cyc(1, 32'h0000_0040, 0, 0, 0);
    check("fl_load_pc4", ifid_pc4, 32'h44);

    // Zero-wait flush: exactly one bubble.
    cyc(1, 32'hBAD0_0000, 0, 1, 32'h50);
    check("zf_bubble", {31'h0, ifid_valid}, 32'h0);
    check("zf_addr", imem_addr, 32'h50);
    cyc(1, 32'h0000_0050, 0, 0, 0);
    check("zf_valid", {31'h0, ifid_valid}, 32'h1);
    check("zf_pc4", ifid_pc4, 32'h54);

    // Flush and stall together in HOLD.
    cyc(1, 32'h1111_2222, 1, 0, 0);
    check("hf_req", {31'h0, imem_req}, 32'h0);
    cyc(0, 0, 1, 1, 32'h80);
    check("hf_valid", {31'h0, ifid_valid}, 32'h0);
    check("hf_instr", ifid_instr, 32'h0);
    check("hf_addr", imem_addr, 32'h80);
    check("hf_req1", {31'h0, imem_req}, 32'h1);
    cyc(1, 32'h0000_0080, 0, 0, 0);
    check("hf_pc4", ifid_pc4, 32'h84);

    // Asynchronous reset mid-transaction.
    rst_n = 1'b0;
    model_reset();
    #1;
    check("ar_req", {31'h0, imem_req}, 32'h0);
    check("ar_addr", imem_addr, 32'h0);
    check("ar_valid", {31'h0, ifid_valid}, 32'h0);
    cyc(0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic a, s, f;
      logic [31:0] t;
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
        cyc(0, 0, 0, 0, 0);
        rst_n = 1'b1;
      end
      a = m_req && ($urandom_range(0, 99) < 60);
      s = ($urandom_range(0, 99) < 20);
      f = ($urandom_range(0, 99) < 8);
      t = $urandom;
      cyc(a, memf(m_pc), s, f, t);
    end

    // Run of zero-wait, no-stall fetches ending near the wrap point.
    cyc(0, 0, 0, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) cyc(m_req, memf(m_pc), 0, 0, 0);

    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
